// File: rtl/midi_uart_rx.sv
// MIDI IN serial receiver: 8N1 at BAUD, mid-bit sampling, valid/ready byte output
// with framing-error pulse and sticky overrun status.
module midi_uart_rx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 31250,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_midi_rx,
  input  logic       i_ready,
  input  logic       i_err_clr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          ovr_nxt;
  logic          ferr_nxt;
  logic          deliver;
  logic          sync1;
  logic          rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_midi_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_cnt     <= bit_nxt;
      shreg       <= shreg_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= ferr_nxt;
      o_overrun   <= ovr_nxt;
    end
  end

  // Frame sequencing: the start bit is checked at its midpoint, after which every
  // full bit period lands in the middle of the next bit.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt + TW'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        tick_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (tick_cnt == HALF_LAST) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_cnt == FULL_LAST) begin
          tick_nxt  = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick_cnt == FULL_LAST) begin
          tick_nxt = '0;
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        tick_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        tick_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Output holding register: a consumer handshake in the delivery cycle frees the
  // slot for the new byte; otherwise the new byte is dropped and overrun latches.
  always_comb begin
    data_nxt  = o_data;
    valid_nxt = o_valid;
    ovr_nxt   = o_overrun;
    if (o_valid && i_ready) valid_nxt = 1'b0;
    if (deliver && (!o_valid || i_ready)) begin
      data_nxt  = shreg;
      valid_nxt = 1'b1;
    end
    if (i_err_clr) ovr_nxt = 1'b0;
    if (deliver && o_valid && !i_ready) ovr_nxt = 1'b1;
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: frame-level reference model plus directed
// literal expectations at hand-computed cycles.
`timescale 1ns/1ps
module tb_midi_uart_rx;

  localparam int     CPB = 800;
  localparam longint LAT = 3 + (19 * CPB) / 2;

  typedef struct {
    longint     cyc;
    logic [7:0] data;
    bit         ok;
  } ev_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_midi_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic       i_err_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  longint     cyc = 0;
  longint     fall;
  int         checks = 0;
  int         failures = 0;
  ev_t        evq[$];
  logic [7:0] abort_byte = 8'hAA;

  logic [7:0] m_data = '0;
  bit         m_valid = 0;
  bit         m_ovr = 0;
  bit         m_ferr = 0;

  midi_uart_rx #(
    .CLK_HZ(25000000),
    .BAUD  (31250)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_midi_rx  (i_midi_rx),
    .i_ready    (i_ready),
    .i_err_clr  (i_err_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #20 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic waitUntil(input longint target);
    while (cyc < target) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  // Drives one wire frame starting now and records what the receiver must report.
  task automatic applyStimulus(input logic [7:0] b, input int stop_len, input bit stop_ok);
    ev_t ev;
    ev.cyc  = cyc + LAT;
    ev.data = b;
    ev.ok   = stop_ok;
    evq.push_back(ev);
    i_midi_rx = 1'b0;
    waitCycles(CPB);
    for (int k = 0; k < 8; k++) begin
      i_midi_rx = b[k];
      waitCycles(CPB);
    end
    i_midi_rx = stop_ok;
    waitCycles(stop_len);
    i_midi_rx = 1'b1;
  endtask

  // Reference model: frame outcomes arrive as events; handshake rules decide outputs.
  always begin
    bit   s_rdy, s_clr, s_rst, prev, set_ovr;
    ev_t  ev;
    @(posedge i_clk);
    s_rdy = i_ready;
    s_clr = i_err_clr;
    s_rst = i_rst;
    #1;
    if (s_rst) begin
      m_data  = '0;
      m_valid = 0;
      m_ovr   = 0;
      m_ferr  = 0;
    end else begin
      m_ferr  = 0;
      set_ovr = 0;
      prev    = m_valid;
      if (prev && s_rdy) m_valid = 0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) m_ferr = 1;
        else if (!prev || s_rdy) begin
          m_data  = ev.data;
          m_valid = 1;
        end else set_ovr = 1;
      end
      if (s_clr) m_ovr = 0;
      if (set_ovr) m_ovr = 1;
    end
    checkOutput("model_valid", 8'(o_valid), 8'(m_valid));
    checkOutput("model_frame_err", 8'(o_frame_err), 8'(m_ferr));
    checkOutput("model_overrun", 8'(o_overrun), 8'(m_ovr));
    if (m_valid) checkOutput("model_data", o_data, m_data);
  end

  initial begin
    waitCycles(5);
    checkOutput("reset_valid", 8'(o_valid), 8'h00);
    checkOutput("reset_data", o_data, 8'h00);
    checkOutput("reset_frame_err", 8'(o_frame_err), 8'h00);
    checkOutput("reset_overrun", 8'(o_overrun), 8'h00);
    checkOutput("reset_busy", 8'(o_busy), 8'h00);
    i_rst = 1'b0;
    waitCycles(20);

    $display("[TB] single byte 0x90");
    fall = cyc;
    fork
      applyStimulus(8'h90, CPB, 1'b1);
      begin
        waitUntil(fall + 2);
        checkOutput("t1_busy_t0", 8'(o_busy), 8'h00);
        waitUntil(fall + 3);
        checkOutput("t1_busy_t0p1", 8'(o_busy), 8'h01);
        waitUntil(fall + LAT - 1);
        checkOutput("t1_busy_stop", 8'(o_busy), 8'h01);
        checkOutput("t1_valid_early", 8'(o_valid), 8'h00);
        waitUntil(fall + LAT);
        checkOutput("t1_valid", 8'(o_valid), 8'h01);
        checkOutput("t1_data", o_data, 8'h90);
        checkOutput("t1_busy_done", 8'(o_busy), 8'h00);
        waitUntil(fall + LAT + 1);
        checkOutput("t1_valid_drop", 8'(o_valid), 8'h00);
      end
    join

    $display("[TB] start glitch");
    waitCycles(50);
    fall = cyc;
    i_midi_rx = 1'b0;
    waitCycles(200);
    i_midi_rx = 1'b1;
    waitUntil(fall + 402);
    checkOutput("t2_busy_sample", 8'(o_busy), 8'h01);
    waitUntil(fall + 403);
    checkOutput("t2_busy_idle", 8'(o_busy), 8'h00);
    waitUntil(fall + 1000);
    checkOutput("t2_no_valid", 8'(o_valid), 8'h00);

    $display("[TB] framing error then clean byte");
    fall = cyc;
    fork
      applyStimulus(8'h3C, 5000, 1'b0);
      begin
        waitUntil(fall + LAT - 1);
        checkOutput("t3_ferr_early", 8'(o_frame_err), 8'h00);
        waitUntil(fall + LAT);
        checkOutput("t3_ferr", 8'(o_frame_err), 8'h01);
        checkOutput("t3_no_valid", 8'(o_valid), 8'h00);
        checkOutput("t3_busy_break", 8'(o_busy), 8'h01);
        waitUntil(fall + LAT + 1);
        checkOutput("t3_ferr_pulse", 8'(o_frame_err), 8'h00);
      end
    join
    waitCycles(100);
    checkOutput("t3_busy_idle", 8'(o_busy), 8'h00);
    fall = cyc;
    fork
      applyStimulus(8'h45, CPB, 1'b1);
      begin
        waitUntil(fall + LAT);
        checkOutput("t3_valid", 8'(o_valid), 8'h01);
        checkOutput("t3_data", o_data, 8'h45);
        checkOutput("t3_ferr_clean", 8'(o_frame_err), 8'h00);
      end
    join

    $display("[TB] back-to-back with consumer stalled");
    waitCycles(50);
    i_ready = 1'b0;
    applyStimulus(8'h90, 420, 1'b1);
    applyStimulus(8'h3C, 420, 1'b1);
    checkOutput("t4_overrun", 8'(o_overrun), 8'h01);
    checkOutput("t4_data_held", o_data, 8'h90);
    fall = cyc;
    fork
      applyStimulus(8'h7F, CPB, 1'b1);
      begin
        waitUntil(fall + LAT - 1);
        i_err_clr = 1'b1;
        waitUntil(fall + LAT);
        i_err_clr = 1'b0;
        checkOutput("t4_set_wins", 8'(o_overrun), 8'h01);
        checkOutput("t4_data_held2", o_data, 8'h90);
        checkOutput("t4_valid_held", 8'(o_valid), 8'h01);
      end
    join
    i_err_clr = 1'b1;
    waitCycles(1);
    i_err_clr = 1'b0;
    checkOutput("t4_overrun_clr", 8'(o_overrun), 8'h00);
    checkOutput("t4_valid_after_clr", 8'(o_valid), 8'h01);

    $display("[TB] ready in delivery cycle");
    waitCycles(20);
    fall = cyc;
    fork
      applyStimulus(8'hA7, CPB, 1'b1);
      begin
        waitUntil(fall + LAT - 1);
        checkOutput("t5_old_pending", o_data, 8'h90);
        i_ready = 1'b1;
        waitUntil(fall + LAT);
        i_ready = 1'b0;
        checkOutput("t5_data_new", o_data, 8'hA7);
        checkOutput("t5_valid", 8'(o_valid), 8'h01);
        checkOutput("t5_no_overrun", 8'(o_overrun), 8'h00);
      end
    join
    i_ready = 1'b1;
    waitCycles(1);
    i_ready = 1'b0;
    checkOutput("t5_valid_consumed", 8'(o_valid), 8'h00);

    $display("[TB] reset mid-frame");
    i_ready = 1'b1;
    waitCycles(50);
    i_midi_rx = 1'b0;
    waitCycles(CPB);
    for (int k = 0; k < 4; k++) begin
      i_midi_rx = abort_byte[k];
      waitCycles(CPB);
    end
    i_midi_rx = abort_byte[4];
    waitCycles(CPB / 2);
    checkOutput("t6_busy_mid", 8'(o_busy), 8'h01);
    i_rst = 1'b1;
    i_midi_rx = 1'b1;
    waitCycles(5);
    checkOutput("t6_busy_rst", 8'(o_busy), 8'h00);
    i_rst = 1'b0;
    waitCycles(200);
    checkOutput("t6_no_valid", 8'(o_valid), 8'h00);
    fall = cyc;
    fork
      applyStimulus(8'h55, CPB, 1'b1);
      begin
        waitUntil(fall + LAT);
        checkOutput("t6_valid", 8'(o_valid), 8'h01);
        checkOutput("t6_data", o_data, 8'h55);
        checkOutput("t6_overrun", 8'(o_overrun), 8'h00);
        checkOutput("t6_ferr", 8'(o_frame_err), 8'h00);
      end
    join
    waitCycles(50);
    checkOutput("t6_valid_consumed", 8'(o_valid), 8'h00);
    checkOutput("t6_busy_end", 8'(o_busy), 8'h00);
    if (evq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL pending_events: got %0d events left expected 0", evq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
